// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the UART TX path: FSM state encodings, frame length and
// the clocks-per-bit derivation shared with the RX block.
package uart_tx_buffered_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   localparam int FRAME_BITS = 10;

   // Truncating division, so the real bit time is never longer than nominal.
   function automatic int baud_div(input int clock_rate, input int baud_rate);
      return clock_rate / baud_rate;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; read data is the current head.
// Overflowing pushes and underflowing pops are ignored.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes queue in a small FIFO and are sent LSB-first.
//
//  state | meaning
//  IDLE  | line high; starts a frame when enabled and the FIFO holds a byte
//  START | start bit (low) for DIV clocks
//  DATA  | eight data bits, DIV clocks each, LSB first
//  STOP  | stop bit (high); may chain straight into the next START
module uart_tx_buffered
   import uart_tx_buffered_pkg::*;
#(
   parameter int CLOCK_RATE = 20000000,
   parameter int BAUD_RATE  = 9600,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] in,
   input  logic       valid,
   output logic       ready,
   output logic       out,
   output logic       busy
);

   localparam int DIV = baud_div(CLOCK_RATE, BAUD_RATE);
   localparam int BW  = $clog2(DIV);
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;

   tx_state_t     state, state_nxt;
   logic [7:0]    shr, shr_nxt;
   logic [2:0]    bit_cnt, bit_cnt_nxt;
   logic [BW-1:0] baud_cnt, baud_cnt_nxt;
   logic          out_nxt;
   logic          pop;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic [7:0]    head;
   logic          baud_tc;

   uart_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (valid & ready),
      .pop   (pop),
      .wdata (in),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign ready   = ~full & ~reset;
   assign busy    = (state != ST_IDLE) | (count != '0);
   assign baud_tc = (baud_cnt == BW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         out      <= 1'b1;
         shr      <= '0;
         bit_cnt  <= '0;
         baud_cnt <= '0;
      end else begin
         state    <= state_nxt;
         out      <= out_nxt;
         shr      <= shr_nxt;
         bit_cnt  <= bit_cnt_nxt;
         baud_cnt <= baud_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      out_nxt      = out;
      shr_nxt      = shr;
      bit_cnt_nxt  = bit_cnt;
      baud_cnt_nxt = baud_tc ? '0 : baud_cnt + 1'b1;
      pop          = 1'b0;
      case (state)
         ST_IDLE: begin
            out_nxt      = 1'b1;
            baud_cnt_nxt = '0;
            if (enable && !empty) begin
               pop         = 1'b1;
               shr_nxt     = head;
               out_nxt     = 1'b0;
               bit_cnt_nxt = '0;
               state_nxt   = ST_START;
            end
         end
         ST_START: begin
            if (baud_tc) begin
               out_nxt     = shr[0];
               shr_nxt     = {1'b0, shr[7:1]};
               bit_cnt_nxt = '0;
               state_nxt   = ST_DATA;
            end
         end
         ST_DATA: begin
            // bit_cnt is the index of the data bit currently on the line.
            if (baud_tc) begin
               if (bit_cnt == 3'd7) begin
                  out_nxt   = 1'b1;
                  state_nxt = ST_STOP;
               end else begin
                  out_nxt     = shr[0];
                  shr_nxt     = {1'b0, shr[7:1]};
                  bit_cnt_nxt = bit_cnt + 3'd1;
               end
            end
         end
         ST_STOP: begin
            if (baud_tc) begin
               if (enable && !empty) begin
                  pop         = 1'b1;
                  shr_nxt     = head;
                  out_nxt     = 1'b0;
                  bit_cnt_nxt = '0;
                  state_nxt   = ST_START;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            out_nxt      = 1'b1;
            baud_cnt_nxt = '0;
            state_nxt    = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at DIV=16: frames are decoded by sampling the
// line mid-bit and compared against hand-chosen bytes.
module tb_uart_tx_buffered;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [7:0] in_data;
   logic       valid;
   logic       ready;
   logic       out;
   logic       busy;

   int vectors     = 0;
   int miscompares = 0;
   int pushed      = 0;
   logic [7:0] feed_q[$];

   always #5 clk = ~clk;

   uart_tx_buffered #(
      .CLOCK_RATE (16),
      .BAUD_RATE  (1),
      .FIFO_DEPTH (4)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .in     (in_data),
      .valid  (valid),
      .ready  (ready),
      .out    (out),
      .busy   (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      check(tag, {31'd0, obs}, {31'd0, exp});
   endtask

   // One clock: a byte counts as pushed when valid&ready held before the edge.
   task automatic step();
      logic acc;
      acc = valid & ready;
      @(posedge clk);
      #1;
      if (acc) begin
         pushed++;
         feed_q.delete(0);
      end
      if (feed_q.size() != 0) begin
         valid   = 1'b1;
         in_data = feed_q[0];
      end else begin
         valid = 1'b0;
      end
   endtask

   task automatic load(input logic [7:0] b);
      feed_q.push_back(b);
      valid   = 1'b1;
      in_data = feed_q[0];
   endtask

   // Entered at the sample point just after the edge that launched the start bit;
   // returns 160 clocks later, which is the next start edge for back-to-back frames.
   task automatic check_frame(input string tag, input logic [7:0] b, input int late_load);
      logic [9:0]  bits;
      logic [31:0] ll;
      bits = {1'b1, b, 1'b0};
      ll   = late_load;
      check1($sformatf("%s_start_edge", tag), out, 1'b0);
      for (int i = 0; i < 10; i++) begin
         repeat (8) step();
         check1($sformatf("%s_bit%0d", tag, i), out, bits[i]);
         check1($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
         for (int j = 0; j < 8; j++) begin
            if (i == 9 && j == 7 && late_load >= 0) load(ll[7:0]);
            step();
         end
      end
   endtask

   initial begin
      reset   = 1'b1;
      enable  = 1'b1;
      valid   = 1'b0;
      in_data = 8'h00;

      // reset state
      step();
      step();
      check1("rst_out", out, 1'b1);
      check1("rst_busy", busy, 1'b0);
      check1("rst_ready", ready, 1'b0);
      check("rst_count", 32'(dut.count), 32'd0);
      reset = 1'b0;
      step();
      check1("post_rst_ready", ready, 1'b1);
      check1("post_rst_out", out, 1'b1);

      // 1: single byte 0x55, start bit on the edge after the push
      load(8'h55);
      step();
      check1("t1_out_push_edge", out, 1'b1);
      check1("t1_busy_push_edge", busy, 1'b1);
      step();
      check_frame("t1_55", 8'h55, -1);
      check1("t1_busy_end", busy, 1'b0);
      check1("t1_out_end", out, 1'b1);

      // 2: four queued bytes while disabled fill the FIFO, then go out gap-free
      enable = 1'b0;
      load(8'hA3);
      load(8'h00);
      load(8'hFF);
      load(8'h81);
      repeat (4) step();
      check1("t2_ready_full", ready, 1'b0);
      check1("t2_busy_full", busy, 1'b1);
      check1("t2_out_idle", out, 1'b1);
      repeat (3) step();
      check1("t2_ready_still_full", ready, 1'b0);
      enable = 1'b1;
      step();
      check1("t2_ready_after_pop", ready, 1'b1);
      check_frame("t2_A3", 8'hA3, -1);
      check_frame("t2_00", 8'h00, -1);
      check_frame("t2_FF", 8'hFF, -1);
      check_frame("t2_81", 8'h81, -1);
      check1("t2_busy_end", busy, 1'b0);
      check1("t2_out_end", out, 1'b1);

      // 3: six bytes with valid held; FIFO absorbs them as space frees up
      pushed = 0;
      load(8'h11);
      load(8'h22);
      load(8'h33);
      load(8'h44);
      load(8'h55);
      load(8'h66);
      step();
      step();
      check_frame("t3_11", 8'h11, -1);
      check("t3_pushed_f1", pushed, 5);
      check1("t3_ready_f1", ready, 1'b1);
      check_frame("t3_22", 8'h22, -1);
      check("t3_pushed_f2", pushed, 6);
      check1("t3_valid_f2", valid, 1'b0);
      check_frame("t3_33", 8'h33, -1);
      check_frame("t3_44", 8'h44, -1);
      check_frame("t3_55", 8'h55, -1);
      check_frame("t3_66", 8'h66, -1);
      check1("t3_busy_end", busy, 1'b0);

      // 4: disable mid-frame with two bytes queued
      load(8'h5A);
      load(8'hC3);
      load(8'h0F);
      step();
      step();
      enable = 1'b0;
      check_frame("t4_5A", 8'h5A, -1);
      check1("t4_out_hold", out, 1'b1);
      check1("t4_busy_hold", busy, 1'b1);
      repeat (20) step();
      check1("t4_out_hold2", out, 1'b1);
      check1("t4_busy_hold2", busy, 1'b1);
      check("t4_count_hold", 32'(dut.count), 32'd2);
      enable = 1'b1;
      step();
      check_frame("t4_C3", 8'hC3, -1);
      check_frame("t4_0F", 8'h0F, -1);
      check1("t4_busy_end", busy, 1'b0);

      // 5: reset during data bit 3 aborts the frame and flushes the FIFO
      load(8'h96);
      load(8'h77);
      step();
      step();
      repeat (68) step();
      check1("t5_bit3_before_rst", out, 1'b0);
      check("t5_count_before_rst", 32'(dut.count), 32'd1);
      reset = 1'b1;
      step();
      check1("t5_rst_out", out, 1'b1);
      check1("t5_rst_ready", ready, 1'b0);
      check1("t5_rst_busy", busy, 1'b0);
      step();
      reset = 1'b0;
      step();
      check("t5_count_after", 32'(dut.count), 32'd0);
      check1("t5_ready_after", ready, 1'b1);
      check1("t5_out_after", out, 1'b1);
      load(8'h3C);
      step();
      check1("t5_busy_push", busy, 1'b1);
      step();
      check_frame("t5_3C", 8'h3C, -1);
      check1("t5_busy_end", busy, 1'b0);

      // 6: push and pop on the same edge with one entry held
      load(8'hE1);
      load(8'h2D);
      step();
      step();
      check("t6_count_idle_pop", 32'(dut.count), 32'd1);
      check_frame("t6_E1", 8'hE1, 8'h4B);
      check("t6_count_stop_pop", 32'(dut.count), 32'd1);
      check_frame("t6_2D", 8'h2D, -1);
      check_frame("t6_4B", 8'h4B, -1);
      check1("t6_busy_end", busy, 1'b0);
      check("t6_count_end", 32'(dut.count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
